// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, state codes,
// datapath select codes and the control word driven by the output decoder.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_HALT      = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  // Instruction class selected at the end of DECODE; unknown opcodes trap to HALT.
  function automatic state_t decode_opcode(input logic [5:0] op, input logic support_j);
    state_t s;
    case (op)
      OP_LW, OP_SW: s = S_MEM_ADDR;
      OP_RTYPE:     s = S_R_EXEC;
      OP_ADDI:      s = S_ADDI_EXEC;
      OP_BEQ:       s = S_BRANCH;
      OP_J:         s = support_j ? S_JUMP : S_HALT;
      default:      s = S_HALT;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-word decode for the multicycle controller; FETCH
// strobes are Mealy-gated by memory readiness.
module mc_output_decode
  import multicycle_control_pkg::*;
(
  input  state_t     i_state,
  input  logic       i_mem_ready,
  input  logic [5:0] i_opcode,
  output ctrl_t      o_ctrl,
  output logic       o_mem_store
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMM_SH2;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.ior_d    = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.ior_d     = 1'b1;
      end
      S_R_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_REGB;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      S_ADDI_WB: o_ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_REGB;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
      S_HALT: o_ctrl.illegal = 1'b1;
      default: o_ctrl = '0;
    endcase
  end

  // MEM_ADDR picks read or write from the opcode captured in DECODE.
  assign o_mem_store = (i_opcode == OP_SW);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS controller: state register and next-state logic, with the
// control word produced by mc_output_decode.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int SUPPORT_J = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] pcSource,
  output logic [1:0] aluOp,
  output logic [3:0] state_o,
  output logic       illegal_op
);

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_opcode;
  ctrl_t      w_ctrl;
  logic       w_mem_store;

  // Reset drops the state to IDLE immediately, so every strobe clears without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_opcode <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_opcode <= opcode;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      w_next = S_FETCH;
      S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:    w_next = decode_opcode(opcode, SUPPORT_J != 0);
      S_MEM_ADDR:  w_next = w_mem_store ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:    w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:    w_next = S_FETCH;
      S_MEM_WR:    w_next = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:    w_next = S_R_WB;
      S_R_WB:      w_next = S_FETCH;
      S_ADDI_EXEC: w_next = S_ADDI_WB;
      S_ADDI_WB:   w_next = S_FETCH;
      S_BRANCH:    w_next = S_FETCH;
      S_JUMP:      w_next = S_FETCH;
      S_HALT:      w_next = S_HALT;
      default:     w_next = S_IDLE;
    endcase
  end

  mc_output_decode u_decode (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .i_opcode    (r_opcode),
    .o_ctrl      (w_ctrl),
    .o_mem_store (w_mem_store)
  );

  assign pcWrite     = w_ctrl.pc_write;
  assign pcWriteCond = w_ctrl.pc_write_cond;
  assign iorD        = w_ctrl.ior_d;
  assign memRead     = w_ctrl.mem_read;
  assign memWrite    = w_ctrl.mem_write;
  assign irWrite     = w_ctrl.ir_write;
  assign regDst      = w_ctrl.reg_dst;
  assign memToReg    = w_ctrl.mem_to_reg;
  assign regWrite    = w_ctrl.reg_write;
  assign aluSrcA     = w_ctrl.alu_src_a;
  assign aluSrcB     = w_ctrl.alu_src_b;
  assign pcSource    = w_ctrl.pc_source;
  assign aluOp       = w_ctrl.alu_op;
  assign illegal_op  = w_ctrl.illegal;
  assign state_o     = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle model comparison plus
// directed instruction scenarios with hand-computed counts and traces.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;

  logic pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic regDst, memToReg, regWrite, aluSrcA, illegal_op;
  logic [1:0] aluSrcB, pcSource, aluOp;
  logic [3:0] state_o;

  logic pcWrite2, pcWriteCond2, iorD2, memRead2, memWrite2, irWrite2;
  logic regDst2, memToReg2, regWrite2, aluSrcA2, illegal_op2;
  logic [1:0] aluSrcB2, pcSource2, aluOp2;
  logic [3:0] state_o2;

  multicycle_control #(.SUPPORT_J(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
    .memWrite(memWrite), .irWrite(irWrite), .regDst(regDst), .memToReg(memToReg),
    .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcSource(pcSource),
    .aluOp(aluOp), .state_o(state_o), .illegal_op(illegal_op)
  );

  multicycle_control #(.SUPPORT_J(0)) dut_nj (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pcWrite(pcWrite2), .pcWriteCond(pcWriteCond2), .iorD(iorD2), .memRead(memRead2),
    .memWrite(memWrite2), .irWrite(irWrite2), .regDst(regDst2), .memToReg(memToReg2),
    .regWrite(regWrite2), .aluSrcA(aluSrcA2), .aluSrcB(aluSrcB2), .pcSource(pcSource2),
    .aluOp(aluOp2), .state_o(state_o2), .illegal_op(illegal_op2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Control word required in each state, written out from the state table.
  function automatic logic [16:0] exp_word(input state_t s, input logic mr);
    logic pw, pwc, iord, mrd, mwr, irw, rd, m2r, rw, asa, ill;
    logic [1:0] asb, psrc, aop;
    {pw, pwc, iord, mrd, mwr, irw, rd, m2r, rw, asa, ill} = '0;
    {asb, psrc, aop} = '0;
    case (s)
      S_FETCH:     begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      S_DECODE:    asb = 2'b11;
      S_MEM_ADDR:  begin asa = 1; asb = 2'b10; end
      S_MEM_RD:    begin mrd = 1; iord = 1; end
      S_MEM_WB:    begin rw = 1; m2r = 1; end
      S_MEM_WR:    begin mwr = 1; iord = 1; end
      S_R_EXEC:    begin asa = 1; aop = 2'b10; end
      S_R_WB:      begin rw = 1; rd = 1; end
      S_ADDI_EXEC: begin asa = 1; asb = 2'b10; end
      S_ADDI_WB:   rw = 1;
      S_BRANCH:    begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      S_JUMP:      begin pw = 1; psrc = 2'b10; end
      S_HALT:      ill = 1;
      default:     ;
    endcase
    return {pw, pwc, iord, mrd, mwr, irw, rd, m2r, rw, asa, asb, psrc, aop, ill};
  endfunction

  // Instruction flow: where each state leads, given opcode and memory readiness.
  function automatic state_t m_next(input state_t s, input logic [5:0] op,
                                    input logic [5:0] lop, input logic mr);
    case (s)
      S_IDLE:      return S_FETCH;
      S_FETCH:     return mr ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (op == 6'b100011 || op == 6'b101011) return S_MEM_ADDR;
        if (op == 6'b000000) return S_R_EXEC;
        if (op == 6'b001000) return S_ADDI_EXEC;
        if (op == 6'b000100) return S_BRANCH;
        if (op == 6'b000010) return S_JUMP;
        return S_HALT;
      end
      S_MEM_ADDR:  return (lop == 6'b101011) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:    return mr ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:    return mr ? S_FETCH : S_MEM_WR;
      S_R_EXEC:    return S_R_WB;
      S_ADDI_EXEC: return S_ADDI_WB;
      S_HALT:      return S_HALT;
      default:     return S_FETCH;
    endcase
  endfunction

  state_t     m_state = S_IDLE;
  logic [5:0] m_op = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= S_IDLE;
      m_op    <= '0;
    end else begin
      if (m_state == S_DECODE) m_op <= opcode;
      m_state <= m_next(m_state, opcode, m_op, mem_ready);
    end
  end

  logic [16:0] w_dut;
  assign w_dut = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, regDst,
                  memToReg, regWrite, aluSrcA, aluSrcB, pcSource, aluOp, illegal_op};

  always @(negedge clk) begin
    chk("model_state", {28'd0, state_o}, {28'd0, m_state});
    chk("model_ctrl", {15'd0, w_dut}, {15'd0, exp_word(m_state, mem_ready)});
  end

  int n_cyc, n_mw, n_rw, n_m2r, n_irw, n_pw, n_mrd, n_strobe, n_ill;
  logic [3:0] trace[$];

  task automatic clr();
    {n_cyc, n_mw, n_rw, n_m2r, n_irw, n_pw, n_mrd, n_strobe, n_ill} = '0;
    trace.delete();
  endtask

  task automatic cyc(input logic mr);
    mem_ready = mr;
    @(negedge clk);
    n_cyc++;
    n_mw  += int'(memWrite);
    n_rw  += int'(regWrite);
    n_m2r += int'(memToReg);
    n_irw += int'(irWrite);
    n_pw  += int'(pcWrite);
    n_mrd += int'(memRead);
    n_ill += int'(illegal_op);
    n_strobe += int'(memRead | memWrite | irWrite | pcWrite | pcWriteCond | regWrite);
    trace.push_back(state_o);
    @(posedge clk);
    #1;
  endtask

  initial begin
    state_t lw_exp[7];
    lw_exp = '{S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_FETCH};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {28'd0, state_o}, S_IDLE);
    chk("reset_illegal", {31'd0, illegal_op}, 0);
    chk("reset_memread", {31'd0, memRead}, 0);

    // lw with memory always ready, starting from reset release
    opcode = OP_LW;
    clr();
    rst_n = 1'b1;
    repeat (6) cyc(1'b1);
    trace.push_back(state_o);
    chk("lw_trace_len", trace.size(), 7);
    for (int i = 0; i < 7; i++) chk("lw_trace", {28'd0, trace[i]}, {28'd0, lw_exp[i]});
    chk("lw_regwrite_cycles", n_rw, 1);
    chk("lw_memtoreg_cycles", n_m2r, 1);

    // sw with three wait cycles in MEM_WR; mem_ready low in DECODE is ignored
    opcode = OP_SW;
    clr();
    cyc(1); cyc(0); cyc(1); cyc(0); cyc(0); cyc(0); cyc(1);
    chk("sw_memwrite_cycles", n_mw, 4);
    chk("sw_regwrite_cycles", n_rw, 0);
    chk("sw_latency", n_cyc, 7);
    chk("sw_then_fetch", {28'd0, state_o}, S_FETCH);

    // R-type with two fetch wait cycles
    opcode = OP_RTYPE;
    clr();
    cyc(0); cyc(0); cyc(1); cyc(1); cyc(1); cyc(1);
    chk("fetch_irwrite_cycles", n_irw, 1);
    chk("fetch_pcwrite_cycles", n_pw, 1);
    chk("fetch_memread_cycles", n_mrd, 3);
    chk("r_then_fetch", {28'd0, state_o}, S_FETCH);

    // beq
    opcode = OP_BEQ;
    clr();
    cyc(1); cyc(1);
    chk("beq_state", {28'd0, state_o}, S_BRANCH);
    chk("beq_aluop", {30'd0, aluOp}, 1);
    chk("beq_pcwritecond", {31'd0, pcWriteCond}, 1);
    chk("beq_pcsource", {30'd0, pcSource}, 1);
    cyc(1);
    chk("beq_latency", n_cyc, 3);
    chk("beq_then_fetch", {28'd0, state_o}, S_FETCH);

    // addi
    opcode = OP_ADDI;
    clr();
    repeat (4) cyc(1);
    chk("addi_regwrite_cycles", n_rw, 1);
    chk("addi_then_fetch", {28'd0, state_o}, S_FETCH);

    // j: decoded by the default instance, illegal for the SUPPORT_J=0 instance
    opcode = OP_J;
    clr();
    cyc(1); cyc(1);
    chk("j_state", {28'd0, state_o}, S_JUMP);
    chk("j_pcwrite", {31'd0, pcWrite}, 1);
    chk("j_pcsource", {30'd0, pcSource}, 2);
    chk("nj_state", {28'd0, state_o2}, S_HALT);
    chk("nj_illegal", {31'd0, illegal_op2}, 1);
    cyc(1);
    chk("j_latency", n_cyc, 3);

    // illegal opcode traps, holds for 10 cycles, recovers through reset
    opcode = 6'b111111;
    cyc(1); cyc(1);
    chk("halt_state", {28'd0, state_o}, S_HALT);
    clr();
    for (int i = 0; i < 10; i++) cyc(i[0]);
    chk("halt_strobes", n_strobe, 0);
    chk("halt_illegal_cycles", n_ill, 10);
    chk("halt_stays", {28'd0, state_o}, S_HALT);
    rst_n = 1'b0;
    #1;
    chk("halt_reset_idle", {28'd0, state_o}, S_IDLE);
    chk("halt_reset_illegal", {31'd0, illegal_op}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("post_reset_idle", {28'd0, state_o}, S_IDLE);
    cyc(1);
    chk("post_reset_fetch", {28'd0, state_o}, S_FETCH);

    // reset asserted while waiting in MEM_RD
    opcode = OP_LW;
    cyc(1); cyc(1); cyc(1);
    mem_ready = 1'b0;
    chk("wait_in_memrd", {28'd0, state_o}, S_MEM_RD);
    #1;
    chk("memrd_read_before", {31'd0, memRead}, 1);
    rst_n = 1'b0;
    #1;
    chk("memrd_read_after", {31'd0, memRead}, 0);
    chk("memrd_iord_after", {31'd0, iorD}, 0);
    chk("memrd_state_after", {28'd0, state_o}, S_IDLE);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_idle", {28'd0, state_o}, S_IDLE);
    cyc(1);
    chk("abort_fetch", {28'd0, state_o}, S_FETCH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
